hazard_stall_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage RV32I core; sits beside the forwarding unit and sequences stage enables and flushes.
- Detects load-use hazards, applies taken-branch/jump flushes, and freezes the whole pipeline while a multi-cycle data-memory access is outstanding.
- Guards memory waits with a timeout and raises a sticky error.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_perf_cnt.sv | 19 +
 rtl/hazard_stall_ctrl.sv | 170 +++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

   typedef enum logic [1:0] {
      INIT     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2
   } hazard_state_t;

   localparam logic [4:0] REG_ZERO   = 5'd0;
   localparam int         WAIT_CNT_W = $clog2(256);

endpackage

// File: rtl/hazard_perf_cnt.sv
// rtl/hazard_perf_cnt.sv - saturating event counter used by the optional performance counters
module hazard_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use/branch/memory-wait stall sequencer; HAZARD_PERF_CNT_EN adds perf counters
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ID_EX_MemRead,
   input  logic [4:0]       ID_EX_rd,
   input  logic [4:0]       IF_ID_rs1,
   input  logic [4:0]       IF_ID_rs2,
   input  logic             IF_ID_rs1_used,
   input  logic             IF_ID_rs2_used,
   input  logic             branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_write,
   output logic             ex_mem_write,
   output logic             mem_wb_write,
   output logic             id_ex_bubble,
   output logic             if_id_flush,
`ifdef HAZARD_PERF_CNT_EN
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] loaduse_cnt,
   output logic [CNT_W-1:0] flush_cnt,
`endif
   output logic             mem_timeout
);

   if ((MEM_TIMEOUT < 2) || (MEM_TIMEOUT > 255) || (CNT_W < 1)) begin : g_bad_param
      $error("hazard_stall_ctrl: illegal MEM_TIMEOUT or CNT_W");
   end

   localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

   hazard_state_t         state, next_state;
   logic [WAIT_CNT_W-1:0] wait_cnt, wait_nxt;
   logic                  raw_freeze, freeze, timeout_set, load_use;
   logic                  do_flush, do_stall;

   assign raw_freeze = dmem_req && !dmem_ready;

   assign load_use = ID_EX_MemRead && (ID_EX_rd != REG_ZERO) &&
                     ((IF_ID_rs1_used && (ID_EX_rd == IF_ID_rs1)) ||
                      (IF_ID_rs2_used && (ID_EX_rd == IF_ID_rs2)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= INIT;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state    <= next_state;
         wait_cnt <= wait_nxt;
         if (timeout_set) begin
            mem_timeout <= 1'b1;
         end
      end
   end

   always_comb begin
      next_state   = state;
      wait_nxt     = wait_cnt;
      timeout_set  = 1'b0;
      freeze       = 1'b0;
      do_flush     = 1'b0;
      do_stall     = 1'b0;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      mem_wb_write = 1'b1;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;

      case (state)
         INIT: begin
            next_state = RUN;
            wait_nxt   = '0;
         end
         RUN: begin
            if (raw_freeze) begin
               freeze     = 1'b1;
               next_state = MEM_WAIT;
               wait_nxt   = WAIT_CNT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (!raw_freeze) begin
               next_state = RUN;
               wait_nxt   = '0;
            end else if (wait_cnt == WAIT_LAST) begin
               // Forced release: the access is treated as complete this cycle
               timeout_set = 1'b1;
               next_state  = RUN;
               wait_nxt    = '0;
            end else begin
               freeze   = 1'b1;
               wait_nxt = wait_cnt + WAIT_CNT_W'(1);
            end
         end
         default: begin
            next_state = INIT;
            wait_nxt   = '0;
         end
      endcase

      if (state == INIT) begin
         id_ex_bubble = 1'b1;
         if_id_flush  = 1'b1;
      end else if (freeze) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         mem_wb_write = 1'b0;
      end else if (branch_taken) begin
         do_flush     = 1'b1;
         id_ex_bubble = 1'b1;
         if_id_flush  = 1'b1;
      end else if (load_use) begin
         do_stall     = 1'b1;
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end

      // Reset holds the pipeline still and keeps NOPs in the front registers
      if (reset) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         mem_wb_write = 1'b0;
         id_ex_bubble = 1'b1;
         if_id_flush  = 1'b1;
         freeze       = 1'b0;
         do_flush     = 1'b0;
         do_stall     = 1'b0;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (freeze),
      .count (stall_cycles)
   );

   hazard_perf_cnt #(.CNT_W(CNT_W)) u_loaduse_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (do_stall),
      .count (loaduse_cnt)
   );

   hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (do_flush),
      .count (flush_cnt)
   );
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - scoreboard bench for hazard_stall_ctrl with MEM_TIMEOUT=4
module tb_hazard_stall_ctrl;

   typedef struct {
      logic [7:0] exp;
      string      name;
   } sb_t;

   // {pc, if_id, id_ex, ex_mem, mem_wb, bubble, flush, timeout}
   localparam logic [7:0] E_RST  = 8'b00000_11_0;
   localparam logic [7:0] E_INIT = 8'b11111_11_0;
   localparam logic [7:0] E_RUN  = 8'b11111_00_0;
   localparam logic [7:0] E_LU   = 8'b00111_10_0;
   localparam logic [7:0] E_FRZ  = 8'b00000_00_0;
   localparam logic [7:0] E_BR   = 8'b11111_11_0;
   localparam logic [7:0] T      = 8'b00000_00_1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ID_EX_MemRead = 1'b0;
   logic [4:0] ID_EX_rd = 5'd0;
   logic [4:0] IF_ID_rs1 = 5'd0;
   logic [4:0] IF_ID_rs2 = 5'd0;
   logic       IF_ID_rs1_used = 1'b0;
   logic       IF_ID_rs2_used = 1'b0;
   logic       branch_taken = 1'b0;
   logic       dmem_req = 1'b0;
   logic       dmem_ready = 1'b0;
   logic       pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
   logic       id_ex_bubble, if_id_flush, mem_timeout;

   sb_t sb_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .ID_EX_MemRead  (ID_EX_MemRead),
      .ID_EX_rd       (ID_EX_rd),
      .IF_ID_rs1      (IF_ID_rs1),
      .IF_ID_rs2      (IF_ID_rs2),
      .IF_ID_rs1_used (IF_ID_rs1_used),
      .IF_ID_rs2_used (IF_ID_rs2_used),
      .branch_taken   (branch_taken),
      .dmem_req       (dmem_req),
      .dmem_ready     (dmem_ready),
      .pc_write       (pc_write),
      .if_id_write    (if_id_write),
      .id_ex_write    (id_ex_write),
      .ex_mem_write   (ex_mem_write),
      .mem_wb_write   (mem_wb_write),
      .id_ex_bubble   (id_ex_bubble),
      .if_id_flush    (if_id_flush),
      .mem_timeout    (mem_timeout)
   );

   wire [7:0] act = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                     id_ex_bubble, if_id_flush, mem_timeout};

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         sb_t e;
         e = sb_q.pop_front();
         n_cmp++;
         if (act !== e.exp) begin
            n_bad++;
            $display("FAIL %s: got %b required %b", e.name, act, e.exp);
         end
      end
   end

   task automatic step(input string nm, input logic rst, input logic ld, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2,
                       input logic br, input logic req, input logic rdy, input logic [7:0] exp);
      @(posedge clk);
      #1;
      reset          = rst;
      ID_EX_MemRead  = ld;
      ID_EX_rd       = rd;
      IF_ID_rs1      = r1;
      IF_ID_rs2      = r2;
      IF_ID_rs1_used = u1;
      IF_ID_rs2_used = u2;
      branch_taken   = br;
      dmem_req       = req;
      dmem_ready     = rdy;
      sb_q.push_back('{exp, nm});
   endtask

   initial begin
      //    name            rst ld rd     rs1    rs2    u1 u2 br rq ry expected
      step("reset_a",       1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, E_RST);
      step("reset_frz",     1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, E_RST);
      step("init",          0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, E_INIT);
      step("run_idle",      0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, E_RUN);
      step("lu_rs2",        0, 1, 5'd5, 5'd1, 5'd5, 1, 1, 0, 0, 0, E_LU);
      step("lu_after",      0, 0, 5'd5, 5'd1, 5'd5, 1, 1, 0, 0, 0, E_RUN);
      step("lu_rd0",        0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0, E_RUN);
      step("lu_rs1_unused", 0, 1, 5'd7, 5'd7, 5'd3, 0, 1, 0, 0, 0, E_RUN);
      step("lu_rs2_unused", 0, 1, 5'd9, 5'd2, 5'd9, 1, 0, 0, 0, 0, E_RUN);
      step("lu_rs1",        0, 1, 5'd7, 5'd7, 5'd3, 1, 1, 0, 0, 0, E_LU);
      step("lu_and_branch", 0, 1, 5'd5, 5'd5, 5'd5, 1, 1, 1, 0, 0, E_BR);
      step("branch_only",   0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, E_BR);
      step("zero_wait",     0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, E_RUN);
      step("wait1",         0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, E_FRZ);
      step("wait2_br",      0, 1, 5'd4, 5'd4, 5'd0, 1, 0, 1, 1, 0, E_FRZ);
      step("wait3",         0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, E_FRZ);
      step("release_lu",    0, 1, 5'd6, 5'd0, 5'd6, 0, 1, 0, 1, 1, E_LU);
      step("after_release", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, E_RUN);
      step("to_wait1",      0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, E_FRZ);
      step("to_wait2",      0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, E_FRZ);
      step("to_wait3",      0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, E_FRZ);
      step("to_forced",     0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, E_RUN);
      step("to_sticky",     0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, E_RUN | T);
      step("to_sticky_br",  0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, E_BR | T);
      step("to_sticky_frz", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, E_FRZ | T);
      step("rst_mid_wait",  1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, E_RST);
      step("init_again",    0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, E_INIT);
      step("run_again",     0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, E_RUN);
      step("post_rst_w1",   0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, E_FRZ);
      step("post_rst_rdy",  0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, E_RUN);
      step("final_idle",    0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, E_RUN);
      @(posedge clk);
      @(posedge clk);
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: %0d left, required 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
